// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: ready/valid FIFO controller wrapped around an external
// simple dual-port block RAM with a one-cycle synchronous read. A 2-entry
// output skid buffer absorbs the RAM read latency so a continuous stream
// moves one word per cycle. Total capacity is DEPTH + 2 words.
// Optional feature: define BRAM_FIFO_LEVEL_EN to add the LEVEL fill-count output.
module bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR,
  output logic [DATA_WIDTH-1:0] RAM_DIN,
  input  logic [DATA_WIDTH-1:0] RAM_DOUT
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   LEVEL
`endif
);

  // RAM depth expressed in the width of the occupancy counter
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic                  inflight;
  logic [1:0]            skid_occ;
  logic [DATA_WIDTH-1:0] skid_head;
  logic [DATA_WIDTH-1:0] skid_tail;

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            buf_load;

  // Handshakes and RAM port drive; pointers read as zero while in reset
  always_comb begin
    IN_READY  = !RST && (mem_count < DEPTH_CNT);
    push      = IN_VALID && IN_READY;
    OUT_VALID = !RST && (skid_occ != 2'd0);
    OUT_DATA  = RST ? '0 : skid_head;
    pop       = OUT_VALID && OUT_READY;
    RAM_WE    = push;
    RAM_DIN   = IN_DATA;
    RAM_WADDR = RST ? '0 : wr_ptr;
    RAM_RADDR = RST ? '0 : rd_ptr;
    // words that will sit in the skid buffer once this cycle settles; a new
    // read is only launched if its data is guaranteed a free slot
    buf_load  = {1'b0, skid_occ} + {2'b00, inflight} - {2'b00, pop};
    issue     = !RST && (mem_count != '0) && (buf_load < 3'd2);
  end

  // Write/read pointers and the count of words still held in the RAM
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
    end
  end

  // Skid buffer: capture the RAM word one cycle after its read was issued,
  // shift towards the head on pop; a read in flight at reset is dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      inflight  <= 1'b0;
      skid_occ  <= 2'd0;
      skid_head <= '0;
      skid_tail <= '0;
    end else begin
      inflight <= issue;
      case ({inflight, pop})
        2'b10: begin
          if (skid_occ == 2'd0)
            skid_head <= RAM_DOUT;
          else
            skid_tail <= RAM_DOUT;
          skid_occ <= skid_occ + 2'd1;
        end
        2'b01: begin
          skid_head <= skid_tail;
          skid_occ  <= skid_occ - 2'd1;
        end
        2'b11: begin
          if (skid_occ == 2'd1) begin
            skid_head <= RAM_DOUT;
          end else begin
            skid_head <= skid_tail;
            skid_tail <= RAM_DOUT;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRAM_FIFO_LEVEL_EN
  // Total words held: in RAM, in the read pipeline and in the skid buffer
  always_comb begin
    LEVEL = RST ? '0 : (mem_count + (ADDR_WIDTH+1)'(inflight) + (ADDR_WIDTH+1)'(skid_occ));
  end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: scoreboard bench for bram_fifo_ctrl with a sync-read
// dual-port RAM model, ADDR_WIDTH=3 (DEPTH 8, capacity 10).
// LEVEL checks are included when BRAM_FIFO_LEVEL_EN is defined.
module tb_bram_fifo_ctrl;

  localparam int DW = 5;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW:0]   level;
`endif

  int n_compared = 0;
  int n_mismatched = 0;

  logic [DW-1:0] sb[$];
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] ram_mem [1<<AW];

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .RAM_WE(ram_we), .RAM_WADDR(ram_waddr), .RAM_RADDR(ram_raddr),
    .RAM_DIN(ram_din), .RAM_DOUT(ram_dout)
`ifdef BRAM_FIFO_LEVEL_EN
    , .LEVEL(level)
`endif
  );

  always #5 clk = ~clk;

  // Sync-read dual-port RAM model
  always @(posedge clk) begin
    if (ram_we)
      ram_mem[ram_waddr] <= ram_din;
    ram_dout <= ram_mem[ram_raddr];
  end

  task automatic check(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: reset outputs, pop-side ordering and hold stability
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_waddr", ram_waddr, 0);
      check("rst_raddr", ram_raddr, 0);
      sb.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL sb_empty: got word %0d expected none at %0t", out_data, $time);
        end else begin
          check("out_data", out_data, sb.pop_front());
        end
      end
      if (in_valid && in_ready)
        sb.push_back(in_data);
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
    end
  end

  task automatic apply_reset(input logic iv);
    next_cycle();
    rst = 1'b1; in_valid = iv; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
  endtask

  task automatic drain(input int cycles);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) next_cycle();
    check("drain_sb_empty", sb.size(), 0);
    check("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    int accepted;
    int nxt;
    int pushed;
    int t;

    // Test 1: reset held two cycles with IN_VALID high
    apply_reset(1'b1);

    // Test 2: single word latency
    next_cycle();
    in_valid = 1'b1; in_data = 5'h15; out_ready = 1'b1;
    @(negedge clk);
    check("t2_c0_we", ram_we, 1);
    check("t2_c0_waddr", ram_waddr, 0);
    next_cycle(); in_valid = 1'b0; @(negedge clk);
    check("t2_c1_raddr", ram_raddr, 0);
    check("t2_c1_valid", out_valid, 0);
    next_cycle(); @(negedge clk);
    check("t2_c2_raddr", ram_raddr, 1);
    check("t2_c2_valid", out_valid, 0);
    next_cycle(); @(negedge clk);
    check("t2_c3_valid", out_valid, 1);
    check("t2_c3_data", out_data, 5'h15);
    next_cycle(); @(negedge clk);
    check("t2_c4_valid", out_valid, 0);

    // Test 3: 32 back-to-back words, pointers wrap four times
    apply_reset(1'b0);
    for (int k = 0; k < 36; k++) begin
      next_cycle();
      out_ready = 1'b1;
      if (k < 32) begin in_valid = 1'b1; in_data = 5'(k); end
      else in_valid = 1'b0;
      @(negedge clk);
      if (k < 32) begin
        check("t3_waddr", ram_waddr, k % 8);
        check("t3_in_ready", in_ready, 1);
      end
      check("t3_out_valid", out_valid, (k >= 3 && k < 35) ? 1 : 0);
    end

    // Test 4: fill to capacity with the consumer stalled, then drain
    apply_reset(1'b0);
    accepted = 0; nxt = 3;
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      in_valid = 1'b1; in_data = 5'(nxt);
      @(negedge clk);
      if (in_ready) begin accepted++; nxt++; end
    end
    check("t4_accepted", accepted, 10);
    check("t4_full_in_ready", in_ready, 0);
    next_cycle(); in_valid = 1'b0; out_ready = 1'b1; @(negedge clk);
    check("t4_drain_c0_in_ready", in_ready, 0);
    next_cycle(); @(negedge clk);
    check("t4_drain_c1_in_ready", in_ready, 1);
    drain(30);

    // Test 5: random flow with a reset pulse mid-stream
    apply_reset(1'b0);
    pushed = 0;
    t = 0;
    while (pushed < 400 && t < 5000) begin
      next_cycle();
      t++;
      if (pushed == 200) begin
        rst = 1'b1; in_valid = 1'b0;
        next_cycle();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t5_post_reset_valid", out_valid, 0);
        check("t5_post_reset_ready", in_ready, 1);
        pushed++;
        next_cycle();
      end
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data = 5'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) pushed++;
    end
    check("t5_budget", (t < 5000) ? 1 : 0, 1);
    drain(40);

`ifdef BRAM_FIFO_LEVEL_EN
    // Test 6: LEVEL tracks pushes and pops, clears on reset
    apply_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      in_valid = 1'b1; in_data = 5'(k + 7);
      @(negedge clk);
      check("t6_level_push", level, k);
    end
    next_cycle(); in_valid = 1'b0; @(negedge clk);
    check("t6_level_full", level, 10);
    for (int j = 0; j < 10; j++) begin
      t = 0;
      while (!out_valid && t < 10) begin next_cycle(); @(negedge clk); t++; end
      next_cycle(); out_ready = 1'b1; @(negedge clk);
      check("t6_level_before_pop", level, 10 - j);
      next_cycle(); out_ready = 1'b0; @(negedge clk);
      check("t6_level_after_pop", level, 9 - j);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); in_valid = 1'b1; in_data = 5'(k);
    end
    next_cycle(); in_valid = 1'b0; rst = 1'b1; @(negedge clk);
    check("t6_level_in_reset", level, 0);
    next_cycle(); rst = 1'b0; @(negedge clk);
    check("t6_level_after_reset", level, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
